// File: rtl/inst_fetch_unit.sv
// IF stage: owns the PC, fetches from instruction memory and registers the IF/ID payload.
// Define INST_FETCH_BPRED_EN to enable the 2-bit BHT predictor for conditional branches.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BHT_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        id_force_jump,
  input  logic [31:0] id_next_pc,
  input  logic        ex_branch_valid,
  input  logic [31:0] ex_branch_pc,
  input  logic        ex_branch_taken,
  input  logic        ex_branch_pred,
  input  logic [31:0] ex_branch_target,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_branch_taken,
  output logic        id_flush
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic        taken_q, taken_d;
  logic        mispredict;
  logic        pred_taken;
  logic [31:0] pred_target;

  assign pc_plus4   = pc_q + 32'd4;
  assign mispredict = ex_branch_valid && (ex_branch_taken != ex_branch_pred);

`ifdef INST_FETCH_BPRED_EN
  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [IdxW-1:0] rd_idx, wr_idx;
  logic [5:0]      opcode;
  logic            is_cond_br;

  assign opcode      = imem_data[31:26];
  assign is_cond_br  = (opcode == 6'd1) || ((opcode >= 6'd4) && (opcode <= 6'd7));
  assign rd_idx      = pc_q[IdxW+1:2];
  assign wr_idx      = ex_branch_pc[IdxW+1:2];
  assign pred_taken  = bht_q[rd_idx][1] & is_cond_br;
  assign pred_target = pc_plus4 + {{14{imem_data[15]}}, imem_data[15:0], 2'b00};

  // Training ignores stall; the lookup above reads the pre-update value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (ex_branch_valid) begin
      if (ex_branch_taken && (bht_q[wr_idx] != 2'b11)) begin
        bht_q[wr_idx] <= bht_q[wr_idx] + 2'd1;
      end else if (!ex_branch_taken && (bht_q[wr_idx] != 2'b00)) begin
        bht_q[wr_idx] <= bht_q[wr_idx] - 2'd1;
      end
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
`endif

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    taken_d = taken_q;
    if (mispredict) begin
      pc_d    = ex_branch_taken ? ex_branch_target : ex_branch_pc + 32'd4;
      inst_d  = '0;
      ipc_d   = '0;
      taken_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (id_force_jump) begin
      // No delay slot: the word fetched behind the jump is dropped.
      pc_d    = id_next_pc;
      inst_d  = '0;
      ipc_d   = '0;
      taken_d = 1'b0;
    end else begin
      pc_d    = pred_taken ? pred_target : pc_plus4;
      inst_d  = imem_data;
      ipc_d   = pc_q;
      taken_d = pred_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      ipc_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      taken_q <= taken_d;
    end
  end

  assign imem_addr       = pc_q;
  assign if_inst         = inst_q;
  assign if_pc           = ipc_q;
  assign if_branch_taken = taken_q;
  assign id_flush        = mispredict;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed vector bench for inst_fetch_unit; expectations follow INST_FETCH_BPRED_EN if defined.
module tb_inst_fetch_unit;

`ifdef INST_FETCH_BPRED_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] BEQ    = 32'h1000_000F;  // beq, imm 0x000F

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_force_jump;
  logic [31:0] id_next_pc;
  logic        ex_branch_valid;
  logic [31:0] ex_branch_pc;
  logic        ex_branch_taken;
  logic        ex_branch_pred;
  logic [31:0] ex_branch_target;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_branch_taken;
  logic        id_flush;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit #(
    .RESET_PC   (RST_PC),
    .BHT_ENTRIES(64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .id_force_jump   (id_force_jump),
    .id_next_pc      (id_next_pc),
    .ex_branch_valid (ex_branch_valid),
    .ex_branch_pc    (ex_branch_pc),
    .ex_branch_taken (ex_branch_taken),
    .ex_branch_pred  (ex_branch_pred),
    .ex_branch_target(ex_branch_target),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .if_branch_taken (if_branch_taken),
    .id_flush        (id_flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        fj;
    logic [31:0] npc;
    logic [31:0] data;
    logic        exv;
    logic [31:0] expc;
    logic        ext;
    logic        exp;
    logic [31:0] extgt;
    logic [31:0] e_addr;
    logic        e_flush;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_tk;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic fj, input logic [31:0] npc,
                              input logic [31:0] data, input logic exv, input logic [31:0] expc,
                              input logic ext, input logic exp, input logic [31:0] extgt,
                              input logic [31:0] e_addr, input logic e_flush,
                              input logic [31:0] e_inst, input logic [31:0] e_pc,
                              input logic e_tk);
    vec_t v;
    v.stall = st;      v.fj = fj;           v.npc = npc;       v.data = data;
    v.exv = exv;       v.expc = expc;       v.ext = ext;       v.exp = exp;
    v.extgt = extgt;   v.e_addr = e_addr;   v.e_flush = e_flush;
    v.e_inst = e_inst; v.e_pc = e_pc;       v.e_tk = e_tk;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    stall            = v.stall;
    id_force_jump    = v.fj;
    id_next_pc       = v.npc;
    imem_data        = v.data;
    ex_branch_valid  = v.exv;
    ex_branch_pc     = v.expc;
    ex_branch_taken  = v.ext;
    ex_branch_pred   = v.exp;
    ex_branch_target = v.extgt;
    #1;
    chk("imem_addr", idx, imem_addr, v.e_addr);
    chk("id_flush", idx, {31'd0, id_flush}, {31'd0, v.e_flush});
    @(posedge clk);
    #1;
    chk("if_inst", idx, if_inst, v.e_inst);
    chk("if_pc", idx, if_pc, v.e_pc);
    chk("if_branch_taken", idx, {31'd0, if_branch_taken}, {31'd0, v.e_tk});
  endtask

  vec_t        t1[$];
  vec_t        t2[$];
  logic [31:0] a;

  initial begin
    a = BP ? 32'h80 : 32'h44;
    // Sequential fetch, stall, jumps, BHT training, stall+mispredict, saturation.
    t1.push_back(mk(0, 0, 0, 32'hA0, 0, 0, 0, 0, 0, RST_PC,        0, 32'hA0, RST_PC, 0));
    t1.push_back(mk(0, 0, 0, 32'hA4, 0, 0, 0, 0, 0, RST_PC + 4,    0, 32'hA4, RST_PC + 4, 0));
    t1.push_back(mk(0, 0, 0, 32'hA8, 0, 0, 0, 0, 0, RST_PC + 8,    0, 32'hA8, RST_PC + 8, 0));
    t1.push_back(mk(0, 1, 32'hC, 32'hAC, 0, 0, 0, 0, 0, RST_PC + 12, 0, 0, 0, 0));
    t1.push_back(mk(0, 0, 0, 32'h0C0C, 0, 0, 0, 0, 0, 32'hC,  0, 32'h0C0C, 32'hC, 0));
    t1.push_back(mk(1, 0, 0, 32'h1010, 0, 0, 0, 0, 0, 32'h10, 0, 32'h0C0C, 32'hC, 0));
    t1.push_back(mk(1, 0, 0, 32'h1010, 0, 0, 0, 0, 0, 32'h10, 0, 32'h0C0C, 32'hC, 0));
    t1.push_back(mk(0, 0, 0, 32'h1010, 0, 0, 0, 0, 0, 32'h10, 0, 32'h1010, 32'h10, 0));
    t1.push_back(mk(0, 0, 0, 32'h1414, 0, 0, 0, 0, 0, 32'h14, 0, 32'h1414, 32'h14, 0));
    t1.push_back(mk(0, 1, 32'h24, 32'h1818, 0, 0, 0, 0, 0, 32'h18, 0, 0, 0, 0));
    t1.push_back(mk(0, 1, 32'h200, 32'h2424, 0, 0, 0, 0, 0, 32'h24, 0, 0, 0, 0));
    t1.push_back(mk(0, 0, 0, 32'h0200, 0, 0, 0, 0, 0, 32'h200, 0, 32'h0200, 32'h200, 0));
    t1.push_back(mk(0, 0, 0, 32'h0204, 1, 32'h40, 1, 0, 32'h80, 32'h204, 1, 0, 0, 0));
    t1.push_back(mk(0, 0, 0, 32'h0080, 1, 32'h40, 1, 0, 32'h80, 32'h80, 1, 0, 0, 0));
    t1.push_back(mk(0, 0, 0, 32'h0080, 1, 32'h40, 1, 0, 32'h80, 32'h80, 1, 0, 0, 0));
    t1.push_back(mk(0, 1, 32'h40, 32'h0080, 0, 0, 0, 0, 0, 32'h80, 0, 0, 0, 0));
    t1.push_back(mk(0, 0, 0, BEQ, 0, 0, 0, 0, 0, 32'h40, 0, BEQ, 32'h40, BP));
    t1.push_back(mk(0, 0, 0, 32'hABCD, 0, 0, 0, 0, 0, a, 0, 32'hABCD, a, 0));
    t1.push_back(mk(1, 0, 0, 32'h0, 1, 32'h60, 0, 1, 32'h999, a + 4, 1, 0, 0, 0));
    t1.push_back(mk(0, 0, 0, 32'h6464, 0, 0, 0, 0, 0, 32'h64, 0, 32'h6464, 32'h64, 0));
    for (int k = 0; k < 5; k++) begin
      t1.push_back(mk(0, 0, 0, 32'h68 + 4 * k, 1, 32'h40, 0, 0, 0, 32'h68 + 4 * k, 0,
                      32'h68 + 4 * k, 32'h68 + 4 * k, 0));
    end
    t1.push_back(mk(0, 1, 32'h40, 32'h7C, 0, 0, 0, 0, 0, 32'h7C, 0, 0, 0, 0));
    t1.push_back(mk(0, 0, 0, BEQ, 0, 0, 0, 0, 0, 32'h40, 0, BEQ, 32'h40, 0));
    t1.push_back(mk(0, 0, 0, 32'h44, 0, 0, 0, 0, 0, 32'h44, 0, 32'h44, 32'h44, 0));

    // After mid-run reset: BHT back to 01; same-cycle lookup sees the old counter.
    t2.push_back(mk(0, 1, 32'h40, 32'h0, 1, 32'h40, 1, 1, 32'h80, RST_PC, 0, 0, 0, 0));
    t2.push_back(mk(0, 0, 0, BEQ, 1, 32'h40, 0, 0, 0, 32'h40, 0, BEQ, 32'h40, BP));
    t2.push_back(mk(0, 1, 32'h40, 32'h0, 0, 0, 0, 0, 0, a, 0, 0, 0, 0));
    t2.push_back(mk(0, 0, 0, BEQ, 0, 0, 0, 0, 0, 32'h40, 0, BEQ, 32'h40, 0));
    t2.push_back(mk(0, 0, 0, 32'h44, 0, 0, 0, 0, 0, 32'h44, 0, 32'h44, 32'h44, 0));

    rst = 1'b1;
    stall = 1'b0; id_force_jump = 1'b0; id_next_pc = '0; imem_data = '0;
    ex_branch_valid = 1'b0; ex_branch_pc = '0; ex_branch_taken = 1'b0;
    ex_branch_pred = 1'b0; ex_branch_target = '0;
    #12;
    chk("rst_addr", 0, imem_addr, RST_PC);
    chk("rst_inst", 0, if_inst, 32'h0);
    chk("rst_pc", 0, if_pc, 32'h0);
    chk("rst_tk", 0, {31'd0, if_branch_taken}, 32'h0);
    chk("rst_flush", 0, {31'd0, id_flush}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (t1[i]) apply(t1[i], i);

    // Asynchronous reset mid-run: state clears without a clock edge.
    imem_data = 32'h0;
    ex_branch_valid = 1'b0;
    stall = 1'b0;
    id_force_jump = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", 1, imem_addr, RST_PC);
    chk("mid_rst_inst", 1, if_inst, 32'h0);
    chk("mid_rst_pc", 1, if_pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (t2[i]) apply(t2[i], 100 + i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
